// File: rtl/stack_reg_file.sv
// stack_reg_file: parametrised LIFO register stack for the stack-processor
// datapath. It supports push, pop and replace-top operations, and exposes the
// top two entries (TOS/NOS) combinationally to the ALU.
// All state changes on the falling edge of clk. Reset is synchronous and
// active-high.
// Optional feature macro: STACK_REG_FILE_STICKY_ERR_EN
//   - Defined: overflow/underflow are sticky until clr_err or reset.
//   - Not defined: overflow/underflow are one-cycle pulses, and clr_err is ignored.
module stack_reg_file #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 16,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] w_data,
  input  logic             clr_err,
  output logic [WIDTH-1:0] tos,
  output logic [WIDTH-1:0] nos,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  output logic             underflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]    sp_q;
  logic [CW-1:0]    sp_d;
  logic             ovf_q;
  logic             ovf_d;
  logic             udf_q;
  logic             udf_d;
  logic             wr_en_s;
  logic [AW-1:0]    wr_idx_s;
  logic             ovf_evt_s;
  logic             udf_evt_s;
  logic [CW-1:0]    sp_m1_s;
  logic [CW-1:0]    sp_m2_s;
  logic             full_s;
  logic             empty_s;

  assign sp_m1_s = sp_q - {{(CW-1){1'b0}}, 1'b1};
  assign sp_m2_s = sp_q - {{(CW-2){1'b0}}, 2'b10};
  assign full_s  = (sp_q == CW'(DEPTH));
  assign empty_s = (sp_q == {CW{1'b0}});

  // Decode the requested operation into pointer update, write and error events.
  always_comb begin
    sp_d      = sp_q;
    wr_en_s   = 1'b0;
    wr_idx_s  = sp_q[AW-1:0];
    ovf_evt_s = 1'b0;
    udf_evt_s = 1'b0;
    case ({push, pop})
      2'b10: begin
        if (!full_s) begin
          wr_en_s  = 1'b1;
          wr_idx_s = sp_q[AW-1:0];
          sp_d     = sp_q + {{(CW-1){1'b0}}, 1'b1};
        end else begin
          ovf_evt_s = 1'b1;
        end
      end
      2'b01: begin
        if (!empty_s) begin
          sp_d = sp_m1_s;
        end else begin
          udf_evt_s = 1'b1;
        end
      end
      2'b11: begin
        // Replace-top is legal even when full because the depth does not change.
        if (!empty_s) begin
          wr_en_s  = 1'b1;
          wr_idx_s = sp_m1_s[AW-1:0];
        end else begin
          udf_evt_s = 1'b1;
        end
      end
      default: begin
        sp_d = sp_q;
      end
    endcase
  end

`ifdef STACK_REG_FILE_STICKY_ERR_EN
  // Sticky error flags: a new event wins over a simultaneous clear.
  always_comb begin
    ovf_d = ovf_evt_s | (ovf_q & ~clr_err);
    udf_d = udf_evt_s | (udf_q & ~clr_err);
  end
`else
  logic unused_clr_err_s;
  assign unused_clr_err_s = clr_err;

  // Pulse error flags: high only for the cycle after the illegal request.
  always_comb begin
    ovf_d = ovf_evt_s;
    udf_d = udf_evt_s;
  end
`endif

  // Stack pointer and error flags. Reset takes priority over any operation.
  always_ff @(negedge clk) begin
    if (reset) begin
      sp_q  <= {CW{1'b0}};
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  // Entry storage is not reset. Writes are suppressed while reset is high.
  always_ff @(negedge clk) begin
    if (wr_en_s && !reset) begin
      mem_q[wr_idx_s] <= w_data;
    end
  end

  // Top-of-stack read. Entries above sp are gated off.
  always_comb begin
    tos = {WIDTH{1'b0}};
    if (!empty_s) begin
      tos = mem_q[sp_m1_s[AW-1:0]];
    end else begin
      tos = {WIDTH{1'b0}};
    end
  end

  // Next-on-stack read. This is valid only with at least two entries.
  always_comb begin
    nos = {WIDTH{1'b0}};
    if (sp_q > {{(CW-1){1'b0}}, 1'b1}) begin
      nos = mem_q[sp_m2_s[AW-1:0]];
    end else begin
      nos = {WIDTH{1'b0}};
    end
  end

  assign count     = sp_q;
  assign full      = full_s;
  assign empty     = empty_s;
  assign overflow  = ovf_q;
  assign underflow = udf_q;

endmodule
